// File: rtl/pc_ret_stack_unit.sv
// PC register with an internal return-address stack for jsb/ret flow control.
// Optional build macro RAS_ERR_TRAP_EN vectors pc to TRAP_PC on stack over/underflow.
module pc_ret_stack_unit #(
  parameter int              PC_W      = 12,
  parameter int              RAS_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC  = {PC_W{1'b0}},
  parameter logic [PC_W-1:0] TRAP_PC   = 12'hFFF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [18:0]                  instruction,
  input  logic [1:0]                   pc_src,
  input  logic                         stack_push,
  input  logic                         stack_pop,
  output logic [PC_W-1:0]              pc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;
  logic [PC_W-1:0]  r_ras [RAS_DEPTH];

  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  w_br_off;
  logic [PC_W-1:0]  w_top;
  logic [PTR_W-1:0] w_top_idx;
  logic [PTR_W-1:0] w_wr_idx;
  logic             w_empty;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic [PC_W-1:0]  w_pc_sel;
  logic [PC_W-1:0]  w_pc_next;
  logic [CNT_W-1:0] w_count_next;
  logic             w_unused_bits;

  assign w_pc_inc  = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign w_br_off  = {{(PC_W-8){instruction[7]}}, instruction[7:0]};
  assign w_top_idx = PTR_W'(r_count - {{(CNT_W-1){1'b0}}, 1'b1});
  assign w_wr_idx  = r_count[PTR_W-1:0];
  assign w_top     = r_ras[w_top_idx];
  assign w_empty   = (r_count == {CNT_W{1'b0}});
  assign w_full    = (r_count == CNT_W'(RAS_DEPTH));

  // Pop wins over push when both are requested; push is then silently dropped.
  assign w_do_pop  = stack_pop & ~w_empty;
  assign w_unf_set = stack_pop & w_empty;
  assign w_do_push = stack_push & ~stack_pop & ~w_full;
  assign w_ovf_set = stack_push & ~stack_pop & w_full;

`ifdef RAS_ERR_TRAP_EN
  assign w_unused_bits = ^instruction[18:PC_W];
`else
  assign w_unused_bits = ^{instruction[18:PC_W], TRAP_PC};
`endif

  // Next-PC select, stack count update and optional error vectoring.
  always_comb begin
    w_pc_sel     = w_pc_inc;
    w_pc_next    = w_pc_inc;
    w_count_next = r_count;
    case (pc_src)
      2'b00: w_pc_sel = w_pc_inc;
      2'b01: w_pc_sel = instruction[PC_W-1:0];
      2'b10: begin
        if (!w_empty) begin
          w_pc_sel = w_top;
        end else begin
          w_pc_sel = w_pc_inc;
        end
      end
      2'b11: w_pc_sel = w_pc_inc + w_br_off;
      default: w_pc_sel = w_pc_inc;
    endcase
`ifdef RAS_ERR_TRAP_EN
    if (w_ovf_set || w_unf_set) begin
      w_pc_next = TRAP_PC;
    end else begin
      w_pc_next = w_pc_sel;
    end
`else
    w_pc_next = w_pc_sel;
`endif
    if (w_do_pop) begin
      w_count_next = r_count - {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (w_do_push) begin
      w_count_next = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      w_count_next = r_count;
    end
  end

  // PC, stack depth and sticky error flags; reset empties the stack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_count <= {CNT_W{1'b0}};
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (en) begin
      r_pc    <= w_pc_next;
      r_count <= w_count_next;
      r_ovf   <= r_ovf | w_ovf_set;
      r_unf   <= r_unf | w_unf_set;
    end else begin
      r_pc    <= r_pc;
      r_count <= r_count;
      r_ovf   <= r_ovf;
      r_unf   <= r_unf;
    end
  end

  // Return-address storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (en && w_do_push) begin
      r_ras[w_wr_idx] <= w_pc_inc;
    end
  end

  assign pc            = r_pc;
  assign ras_count     = r_count;
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;

endmodule

// File: tb/tb_pc_ret_stack_unit.sv
// Scoreboard bench for pc_ret_stack_unit: directed steps queue expected state,
// a monitor compares after each clock edge.
module tb_pc_ret_stack_unit;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [18:0] instruction;
  logic [1:0]  pc_src;
  logic        stack_push;
  logic        stack_pop;
  logic [11:0] pc;
  logic [3:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  typedef struct {
    int          idx;
    logic [11:0] pc;
    logic [3:0]  cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t exp_q[$];

`ifdef RAS_ERR_TRAP_EN
  localparam logic [11:0] OVF_PC   = 12'hFFF;
  localparam logic [11:0] UNF_PC20 = 12'hFFF;
  localparam logic [11:0] UNF_PC0  = 12'hFFF;
`else
  localparam logic [11:0] OVF_PC   = 12'h100;
  localparam logic [11:0] UNF_PC20 = 12'h021;
  localparam logic [11:0] UNF_PC0  = 12'h001;
`endif

  pc_ret_stack_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .instruction  (instruction),
    .pc_src       (pc_src),
    .stack_push   (stack_push),
    .stack_pop    (stack_pop),
    .pc           (pc),
    .ras_count    (ras_count),
    .ras_overflow (ras_overflow),
    .ras_underflow(ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  // Monitor: the DUT presents new state after every edge; compare it with the queued expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk($sformatf("step%0d_pc", e.idx), pc, e.pc);
      chk($sformatf("step%0d_cnt", e.idx), {8'h00, ras_count}, {8'h00, e.cnt});
      chk($sformatf("step%0d_ovf", e.idx), {11'h000, ras_overflow}, {11'h000, e.ovf});
      chk($sformatf("step%0d_unf", e.idx), {11'h000, ras_underflow}, {11'h000, e.unf});
    end
  end

  task automatic step(input logic e_n, input logic [18:0] ins, input logic [1:0] src,
                      input logic psh, input logic pop, input logic [11:0] e_pc,
                      input logic [3:0] e_cnt, input logic e_ovf, input logic e_unf);
    exp_t e;
    @(negedge clk);
    en          = e_n;
    instruction = ins;
    pc_src      = src;
    stack_push  = psh;
    stack_pop   = pop;
    step_no++;
    e.idx = step_no;
    e.pc  = e_pc;
    e.cnt = e_cnt;
    e.ovf = e_ovf;
    e.unf = e_unf;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pc"}, pc, 12'h000);
    chk({tag, "_cnt"}, {8'h00, ras_count}, 12'h000);
    chk({tag, "_ovf"}, {11'h000, ras_overflow}, 12'h000);
    chk({tag, "_unf"}, {11'h000, ras_underflow}, 12'h000);
  endtask

  initial begin
    rst_n       = 1'b0;
    en          = 1'b0;
    instruction = 19'h00000;
    pc_src      = 2'b00;
    stack_push  = 1'b0;
    stack_pop   = 1'b0;
    #3;
    check_reset_state("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_state("reset_release");

    // Sequential flow
    step(1'b1, 19'h00000, 2'b00, 1'b0, 1'b0, 12'h001, 4'd0, 1'b0, 1'b0);
    step(1'b1, 19'h00000, 2'b00, 1'b0, 1'b0, 12'h002, 4'd0, 1'b0, 1'b0);
    step(1'b1, 19'h00000, 2'b00, 1'b0, 1'b0, 12'h003, 4'd0, 1'b0, 1'b0);
    step(1'b1, 19'h00000, 2'b00, 1'b0, 1'b0, 12'h004, 4'd0, 1'b0, 1'b0);
    step(1'b1, 19'h00000, 2'b00, 1'b0, 1'b0, 12'h005, 4'd0, 1'b0, 1'b0);
    // jsb to 0x040, two sequential steps, ret to 0x006
    step(1'b1, 19'h00040, 2'b01, 1'b1, 1'b0, 12'h040, 4'd1, 1'b0, 1'b0);
    step(1'b1, 19'h00000, 2'b00, 1'b0, 1'b0, 12'h041, 4'd1, 1'b0, 1'b0);
    step(1'b1, 19'h00000, 2'b00, 1'b0, 1'b0, 12'h042, 4'd1, 1'b0, 1'b0);
    step(1'b1, 19'h00000, 2'b10, 1'b0, 1'b1, 12'h006, 4'd0, 1'b0, 1'b0);
    // Branches: backward -4 from 0x010, forward +5 from 0x00D, upper bits ignored
    step(1'b1, 19'h7F010, 2'b01, 1'b0, 1'b0, 12'h010, 4'd0, 1'b0, 1'b0);
    step(1'b1, 19'h000FC, 2'b11, 1'b0, 1'b0, 12'h00D, 4'd0, 1'b0, 1'b0);
    step(1'b1, 19'h00005, 2'b11, 1'b0, 1'b0, 12'h013, 4'd0, 1'b0, 1'b0);
    // Wrap 0xFFF -> 0x000
    step(1'b1, 19'h00FFF, 2'b01, 1'b0, 1'b0, 12'hFFF, 4'd0, 1'b0, 1'b0);
    step(1'b1, 19'h00000, 2'b00, 1'b0, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0);
    // Eight nested jsb: at pc 0x0k0 jump to 0x0(k+1)0, pushing 0x0k1
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 19'(12'h010 * (k + 1)), 2'b01, 1'b1, 1'b0,
           12'(12'h010 * (k + 1)), 4'(k + 1), 1'b0, 1'b0);
    end
    // Ninth jsb overflows
    step(1'b1, 19'h00100, 2'b01, 1'b1, 1'b0, OVF_PC, 4'd8, 1'b1, 1'b0);
    // Eight returns in LIFO order: 0x071, 0x061, ..., 0x001
    for (int k = 7; k >= 0; k--) begin
      step(1'b1, 19'h00000, 2'b10, 1'b0, 1'b1, 12'(12'h010 * k + 12'h001), 4'(k), 1'b1, 1'b0);
    end
    // Underflow at 0x020
    step(1'b1, 19'h00020, 2'b01, 1'b0, 1'b0, 12'h020, 4'd0, 1'b1, 1'b0);
    step(1'b1, 19'h00000, 2'b10, 1'b0, 1'b1, UNF_PC20, 4'd0, 1'b1, 1'b1);
    // Enable low holds everything even with a jsb presented
    step(1'b1, 19'h00030, 2'b01, 1'b0, 1'b0, 12'h030, 4'd0, 1'b1, 1'b1);
    step(1'b0, 19'h00123, 2'b01, 1'b1, 1'b0, 12'h030, 4'd0, 1'b1, 1'b1);
    // Build depth 2, then push+pop together: pop wins
    step(1'b1, 19'h00200, 2'b01, 1'b1, 1'b0, 12'h200, 4'd1, 1'b1, 1'b1);
    step(1'b1, 19'h00300, 2'b01, 1'b1, 1'b0, 12'h300, 4'd2, 1'b1, 1'b1);
    step(1'b1, 19'h00000, 2'b10, 1'b1, 1'b1, 12'h201, 4'd1, 1'b1, 1'b1);
    // Pop with pc_src=00 pops but does not redirect; ret with empty stack goes sequential
    step(1'b1, 19'h00000, 2'b00, 1'b0, 1'b1, 12'h202, 4'd0, 1'b1, 1'b1);
    step(1'b1, 19'h00000, 2'b10, 1'b0, 1'b0, 12'h203, 4'd0, 1'b1, 1'b1);
    // jsb, then reset mid-call-chain
    step(1'b1, 19'h00400, 2'b01, 1'b1, 1'b0, 12'h400, 4'd1, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check_reset_state("reset_midchain");
    @(negedge clk);
    rst_n = 1'b1;
    // Return after reset must not reach 0x204
    step(1'b1, 19'h00000, 2'b10, 1'b0, 1'b1, UNF_PC0, 4'd0, 1'b0, 1'b1);

    #5;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_ret_stack_unit.md
Name: pc_ret_stack_unit

Overview:
Program-counter stage directly upstream of the instruction memory and controller. Holds the PC register and an internal return-address stack (RAS). Each cycle it consumes the controller's pc_src, stack_push and stack_pop together with the current 19-bit instruction, and produces the next PC. Supports sequential flow, unconditional jump, jump-to-subroutine (jsb), return (ret) and conditional relative branch.

Parameters:
PC_W, 12, PC and return-address width in bits; instruction-memory word address.
RAS_DEPTH, 8, number of RAS entries; power of two, at least 2.
RESET_PC, 0, PC value loaded on reset.
TRAP_PC, 12'hFFF, vector used only when RAS_ERR_TRAP_EN is defined.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  advance enable; low = hold all state
instruction  input  19  current instruction (target/offset fields)
pc_src  input  2  00 seq, 01 jump, 10 return, 11 branch taken
stack_push  input  1  push return address (jsb)
stack_pop  input  1  pop return address (ret)
pc  output  PC_W  current PC to instruction memory
ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries
ras_overflow  output  1  sticky: push attempted while full
ras_underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (async assert, sync-free deassert): pc=RESET_PC, ras_count=0, both error flags 0; RAS contents don't-care.
- All updates on posedge clk when en=1. en=0: pc, RAS, count, flags all held.
- pc_inc = pc+1, modulo 2^PC_W (wraps 0xFFF->0x000).
- Next pc by pc_src:
  - 00: pc_inc.
  - 01: instruction[PC_W-1:0] (absolute target).
  - 10: RAS top entry, if ras_count>0. Otherwise pc_inc.
  - 11: pc_inc + sign_extend(instruction[7:0]), modulo 2^PC_W.
- Push (stack_push=1, normally with pc_src=01): writes pc_inc to RAS[count], count+1, same edge as the jump.
  - Full (count==RAS_DEPTH): no write, count unchanged, ras_overflow<=1. The jump still occurs.
- Pop (stack_pop=1, normally with pc_src=10): count-1, pc<=RAS[count-1].
  - Empty: count unchanged, ras_underflow<=1, pc<=pc_inc.
- Push and pop asserted together: pop executes, push ignored, no error flag.
- stack_push/stack_pop with an inconsistent pc_src: the stack operation still executes. pc follows pc_src, except that pop with pc_src!=10 does not redirect.
- Latency: a redirect is visible on pc one cycle after the qualifying inputs are sampled. pc is a register output, not combinational from inputs.
- Error flags clear only on reset.
- Reset asserted mid-call-chain: stack is emptied; no return to pre-reset addresses.

Optional Feature:
RAS_ERR_TRAP_EN
- Defined: on the edge that sets ras_overflow or ras_underflow, pc<=TRAP_PC instead of the jump target or pc_inc. The flag is set as normal.
- Undefined: no vectoring; behaviour exactly as described above. TRAP_PC is unused.

Test Plan:
- Reset: hold rst_n=0 mid-cycle -> pc=0, ras_count=0, flags 0 immediately (async). Then 3 cycles of pc_src=00 -> pc=1,2,3.
- Jsb/ret: at pc=0x005, instruction[11:0]=0x040, pc_src=01, push=1 -> pc=0x040, count=1. Two seq cycles, then pc_src=10, pop=1 -> pc=0x006, count=0.
- Branch: pc=0x010, instruction[7:0]=0xFC, pc_src=11 -> pc=0x00D. pc=0xFFF with pc_src=00 -> pc=0x000.
- Overflow: 8 nested jsb, then a 9th jsb to 0x100 -> count stays 8, ras_overflow=1, pc=0x100 (0xFFF with RAS_ERR_TRAP_EN). Then 8 pops return correct addresses in LIFO order.
- Underflow: empty stack, pop at pc=0x020 -> pc=0x021, ras_underflow=1, count=0.
- Enable and simultaneous ops: en=0 with pc_src=01 -> pc unchanged. Push+pop together with count=2 -> count=1, pc=popped value.
